led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 109 ++++++++++
 tb/tb_led_pattern_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick drives one of four run-time patterns
// (rotate left/right, bounce, drain/reload) onto LED_W board LEDs.
//
// dir state  | meaning
// DIR_LEFT   | bounce pattern moving toward the MSB
// DIR_RIGHT  | bounce pattern moving toward bit0
module led_pattern_gen #(
    parameter int LED_W    = 4,
    parameter int TICK_DIV = 25000000,
    parameter int CW       = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [LED_W-1:0] led,
    output logic             step_pulse
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [31:0] DIV32 = 32'(TICK_DIV);

    logic [CW-1:0]    cnt, cnt_d;
    logic [1:0]       mode_q, mode_d;
    dir_t             dir, dir_d;
    logic [LED_W-1:0] led_d;
    logic             pulse_d;
    logic [31:0]      limit_m1;
    logic             tick;
    logic             one_hot;

    function automatic logic [LED_W-1:0] seed(input logic [1:0] m);
        logic [LED_W-1:0] s;
        s = '0;
        case (m)
            2'b00:   s[0] = 1'b1;
            2'b01:   s[LED_W-1] = 1'b1;
            2'b10:   s[0] = 1'b1;
            default: s = '1;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mode_q     <= 2'b00;
            dir        <= DIR_LEFT;
            led        <= LED_W'(1);
            step_pulse <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            mode_q     <= mode_d;
            dir        <= dir_d;
            led        <= led_d;
            step_pulse <= pulse_d;
        end
    end

    always_comb begin
        cnt_d    = cnt;
        mode_d   = mode_q;
        dir_d    = dir;
        led_d    = led;
        pulse_d  = 1'b0;
        // The >= compare lets a speed change mid-count tick immediately when cnt
        // already exceeds the new, shorter limit.
        limit_m1 = (DIV32 >> speed) - 32'd1;
        tick     = en && (32'(cnt) >= limit_m1);
        one_hot  = (led != '0) && ((led & (led - LED_W'(1))) == '0);

        if (mode != mode_q) begin
            mode_d = mode;
            led_d  = seed(mode);
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
        end else if (en) begin
            if (tick) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                case (mode_q)
                    2'b00: led_d = one_hot ? {led[LED_W-2:0], led[LED_W-1]} : seed(mode_q);
                    2'b01: led_d = one_hot ? {led[0], led[LED_W-1:1]} : seed(mode_q);
                    2'b10: begin
                        if (!one_hot) begin
                            led_d = seed(mode_q);
                            dir_d = DIR_LEFT;
                        end else if (dir == DIR_LEFT) begin
                            led_d = led << 1;
                            if (led_d[LED_W-1]) dir_d = DIR_RIGHT;
                        end else begin
                            led_d = led >> 1;
                            if (led_d[0]) dir_d = DIR_LEFT;
                        end
                    end
                    default: led_d = (led == '0) ? '1 : (led << 1);
                endcase
            end else begin
                cnt_d = cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (LED_W=4, TICK_DIV=8): stimulus queues the
// expected led value and arrival cycle of each step; a monitor checks on step_pulse.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] led;
    logic       step_pulse;

    typedef struct {
        logic [3:0] led;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   r;
    int   b;

    led_pattern_gen #(.LED_W(4), .TICK_DIV(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .speed      (speed),
        .led        (led),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && step_pulse) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_step: got led %0h at cycle %0d expected no step", led, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_led", 32'(led), 32'(e.led));
                check("step_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic [3:0] v, input int c);
        exp_t e;
        e.led = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive a new mode at the current negedge; the seed must appear one cycle later
    // with no strobe.
    task automatic do_reload(input logic [1:0] m, input logic [3:0] s);
        mode = m;
        @(negedge clk);
        check("reload_led", 32'(led), 32'(s));
        check("reload_pulse", 32'(step_pulse), 32'd0);
        r = cyc;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        speed = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 32'h1);
        check("reset_pulse", 32'(step_pulse), 32'd0);

        // rotate left, first step 8 cycles after release
        rst_n = 1'b1;
        b = cyc;
        push(4'h2, b + 8);
        push(4'h4, b + 16);
        push(4'h8, b + 24);
        push(4'h1, b + 32);
        push(4'h2, b + 40);
        wait_until(b + 40);

        // bounce
        do_reload(2'b10, 4'h1);
        push(4'h2, r + 8);
        push(4'h4, r + 16);
        push(4'h8, r + 24);
        push(4'h4, r + 32);
        push(4'h2, r + 40);
        push(4'h1, r + 48);
        push(4'h2, r + 56);
        push(4'h4, r + 64);
        push(4'h8, r + 72);
        wait_until(r + 72);

        // drain / reload
        do_reload(2'b11, 4'hF);
        push(4'hE, r + 8);
        push(4'hC, r + 16);
        push(4'h8, r + 24);
        push(4'h0, r + 32);
        push(4'hF, r + 40);
        push(4'hE, r + 48);
        wait_until(r + 48);

        // speed change at cnt=6
        do_reload(2'b00, 4'h1);
        push(4'h2, r + 7);
        push(4'h4, r + 9);
        push(4'h8, r + 11);
        push(4'h1, r + 13);
        push(4'h2, r + 15);
        wait_until(r + 6);
        speed = 2'b10;
        wait_until(r + 15);
        speed = 2'b00;

        // pause at led=4 with cnt=3; 4 counts remain after resume
        push(4'h4, r + 23);
        wait_until(r + 26);
        en = 1'b0;
        wait_until(r + 46);
        check("pause_led", 32'(led), 32'h4);
        en = 1'b1;
        push(4'h8, r + 51);
        push(4'h1, r + 59);
        wait_until(r + 59);

        // mode change coincident with a due tick
        wait_until(r + 66);
        do_reload(2'b01, 4'h8);
        push(4'h4, r + 8);
        wait_until(r + 11);

        // asynchronous reset mid-period
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h1);
        check("async_rst_pulse", 32'(step_pulse), 32'd0);
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        b = cyc;
        push(4'h2, b + 8);
        push(4'h4, b + 16);
        wait_until(b + 20);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_step: got none expected led %0h at cycle %0d", e.led, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
